vslc_scan_scheduler: RTL and testbench
======================================

Name: vslc_scan_scheduler

Overview:
- Sequences one VSLC core scan cycle: input sample → program restart → execute → output commit → idle until the scan period expires.
- Sits between the board/TT I/O pins and tt_um_jimktrains_vslc_core. It gates core execution and provides a stable input image, an output-latch strobe, the scan_cycle_clk indicator and overrun/watchdog status.

Parameters:
- PERIOD_W, 24, width of scan-period register and period timer (clk cycles).
- WDOG_LIMIT, 65535, maximum EXEC cycles before a fault is declared.
- CNT_W, 16, width of scan counter and last-scan-length register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; scans start only while high.
- period  in  PERIOD_W  target scan length in clk cycles; sampled at SAMPLE.
- ui_in  in  8  raw input pins.
- core_done  in  1  core reached end of program.
- overrun_clr  in  1  clears sticky overrun.
- in_image  out  8  input image latched at SAMPLE, stable for the whole scan.
- in_strobe  out  1  1-cycle pulse in SAMPLE.
- core_restart  out  1  1-cycle pulse; core resets its PC.
- core_run  out  1  high throughout EXEC.
- out_commit  out  1  1-cycle pulse; core output register latches.
- scan_cycle_clk  out  1  toggles at every SAMPLE entry.
- overrun  out  1  sticky; a scan exceeded period.
- fault  out  1  sticky; watchdog expired.
- scan_count  out  CNT_W  completed scans, wraps modulo 2^CNT_W.
- last_scan_len  out  CNT_W  length of the previous scan in cycles, saturating at all-ones.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer, exec counter and period_q all 0.
- States: IDLE, SAMPLE, RESTART, EXEC, COMMIT, WAIT, FAULT.
- IDLE: when en=1, go to SAMPLE on the next cycle.
- SAMPLE (1 cycle):
  - in_image<=ui_in; period_q<=period; timer<=1; in_strobe=1; scan_cycle_clk toggles.
  - Timer cycle index 0 is the SAMPLE cycle.
- RESTART (1 cycle): core_restart=1. core_done is ignored here.
- EXEC:
  - core_run=1; exec counter increments each cycle.
  - core_done=1 → COMMIT on the next cycle.
  - If the exec counter reaches WDOG_LIMIT with core_done=0 → FAULT.
  - If core_done and the limit occur in the same cycle, core_done wins.
- COMMIT (1 cycle):
  - out_commit=1; scan_count++ (wrap); last_scan_len<=timer+1 (saturating).
  - If timer ≥ period_q (scan longer than period) → overrun<=1.
- Exit from COMMIT or WAIT:
  - If timer+1 ≥ period_q, go to SAMPLE when en=1, else IDLE.
  - Otherwise go to or stay in WAIT.
- Timer: increments every cycle from SAMPLE to the end of the scan; saturates at all-ones.
- Scan length = max(period_q, natural length). Minimum natural length is 4 cycles: SAMPLE, RESTART, 1 EXEC cycle, COMMIT.
- period 0..4 gives back-to-back scans with no WAIT and does not set overrun.
- en deasserted mid-scan: the scan completes through COMMIT (and WAIT), then goes to IDLE. No scan is aborted.
- Changes to period or ui_in mid-scan have no effect until the next SAMPLE.
- overrun_clr clears overrun. If set and clear occur in the same cycle, set wins.
- FAULT: core_run=0, fault=1, no further strobes. FAULT is left only by rst.
- rst mid-scan: everything returns to reset values on the next edge. No out_commit is issued.

Decomposition:
- Shared package vslc_pkg holds:
  - scan_state_t enum (7 states, 3-bit encoding).
  - SCAN_MIN_LEN=4.
  - Default WDOG_LIMIT constant.
- One sub-module, vslc_scan_timer: period timer with saturating increment, load-to-1 and expire compare (timer+1 ≥ period_q). Everything else lives in the FSM.

Test Plan:
- Reset release, en=1, period=10, core_done asserted on the 3rd EXEC cycle → in_strobe at t0, core_restart at t1, out_commit at t5, next in_strobe at t10; scan_count=1, last_scan_len=6, overrun=0.
- period=6, core_done after 8 EXEC cycles → out_commit at t10, overrun=1, next SAMPLE at t11; overrun_clr pulse → overrun=0, but a simultaneous new overrun keeps it 1.
- period=0, core_done held high → scans every 4 cycles; scan_cycle_clk toggles every 4 cycles; overrun stays 0.
- ui_in=0xA5 at SAMPLE, changed to 0x3C during EXEC → in_image stays 0xA5 until the next SAMPLE, then reads 0x3C.
- WDOG_LIMIT=16, core_done never asserted → fault=1 and core_run=0 after 16 EXEC cycles; remains in FAULT until rst, after which all outputs are 0.
- en dropped during EXEC → out_commit still issued, then IDLE with no further in_strobe; rst pulsed during WAIT → scan_count=0, state IDLE.

Source files
------------

// File: rtl/vslc_pkg.sv
// Shared types and constants for the VSLC scan scheduler.
package vslc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_RESTART = 3'd2,
        ST_EXEC    = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_WAIT    = 3'd5,
        ST_FAULT   = 3'd6
    } scan_state_t;

    // SAMPLE + RESTART + one EXEC cycle + COMMIT
    localparam int SCAN_MIN_LEN = 4;

    localparam int WDOG_LIMIT_DEFAULT = 65535;

endpackage

// File: rtl/vslc_scan_scheduler_if.sv
// Pin/core-facing signal bundle of the scan scheduler.
interface vslc_scan_scheduler_if #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
);
    logic                en;
    logic [PERIOD_W-1:0] period;
    logic [7:0]          ui_in;
    logic                core_done;
    logic                overrun_clr;

    logic [7:0]          in_image;
    logic                in_strobe;
    logic                core_restart;
    logic                core_run;
    logic                out_commit;
    logic                scan_cycle_clk;
    logic                overrun;
    logic                fault;
    logic [CNT_W-1:0]    scan_count;
    logic [CNT_W-1:0]    last_scan_len;

    modport master (
        output en, period, ui_in, core_done, overrun_clr,
        input  in_image, in_strobe, core_restart, core_run, out_commit,
               scan_cycle_clk, overrun, fault, scan_count, last_scan_len
    );

    modport slave (
        input  en, period, ui_in, core_done, overrun_clr,
        output in_image, in_strobe, core_restart, core_run, out_commit,
               scan_cycle_clk, overrun, fault, scan_count, last_scan_len
    );

endinterface

// File: rtl/vslc_scan_timer.sv
// Scan period timer: loads 1 on SAMPLE, saturating increment, expire when timer+1 >= period.
module vslc_scan_timer
    import vslc_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                inc_i,
    input  logic [PERIOD_W-1:0] period_q_i,
    output logic [PERIOD_W-1:0] timer_o,
    output logic                expire_o
);

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] timer_d;
    logic [PERIOD_W:0]   timer_p1;

    assign timer_p1 = {1'b0, timer_q} + (PERIOD_W+1)'(1);

    always_comb begin
        timer_d = timer_q;
        if (load_i) begin
            timer_d = PERIOD_W'(1);
        end else if (inc_i && !(&timer_q)) begin
            timer_d = timer_p1[PERIOD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_o  = timer_q;
    assign expire_o = (timer_p1 >= {1'b0, period_q_i});

endmodule

// File: rtl/vslc_scan_scheduler.sv
// Sequences one VSLC core scan: sample inputs, restart core, execute, commit, pad to period.
//
// state   | meaning
// IDLE    | waiting for en
// SAMPLE  | latch ui_in and period, toggle scan_cycle_clk
// RESTART | core PC reset pulse
// EXEC    | core running until core_done or watchdog
// COMMIT  | core outputs latch, scan statistics update
// WAIT    | pad scan out to the sampled period
// FAULT   | watchdog expired, held until rst
module vslc_scan_scheduler
    import vslc_pkg::*;
#(
    parameter int PERIOD_W   = 24,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vslc_scan_scheduler_if.slave  bus
);

    localparam int EXEC_W = $clog2(WDOG_LIMIT + 1);

    scan_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] period_q;
    logic [EXEC_W-1:0]   exec_cnt_q;
    logic [7:0]          in_image_q;
    logic                in_strobe_q, core_restart_q, core_run_q, out_commit_q;
    logic                scan_clk_q, overrun_q, fault_q;
    logic [CNT_W-1:0]    scan_count_q, last_len_q;

    logic [PERIOD_W-1:0] timer;
    logic                expire;
    logic                wdog_hit;
    logic [PERIOD_W-1:0] eff_period;
    logic                scan_late;
    logic [PERIOD_W:0]   len_p1;
    logic [CNT_W-1:0]    len_sat;

    vslc_scan_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_SAMPLE),
        .inc_i      (state_q inside {ST_RESTART, ST_EXEC, ST_COMMIT, ST_WAIT}),
        .period_q_i (period_q),
        .timer_o    (timer),
        .expire_o   (expire)
    );

    assign wdog_hit = (exec_cnt_q == EXEC_W'(WDOG_LIMIT - 1));

    // Periods below the natural minimum cannot be met, so they never flag overrun.
    assign eff_period = (period_q < PERIOD_W'(SCAN_MIN_LEN)) ? PERIOD_W'(SCAN_MIN_LEN) : period_q;
    assign scan_late  = (timer >= eff_period);

    assign len_p1  = {1'b0, timer} + (PERIOD_W+1)'(1);
    assign len_sat = (|len_p1[PERIOD_W:CNT_W]) ? {CNT_W{1'b1}} : len_p1[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.en) state_d = ST_SAMPLE;
            ST_SAMPLE:  state_d = ST_RESTART;
            ST_RESTART: state_d = ST_EXEC;
            ST_EXEC: begin
                if (bus.core_done)  state_d = ST_COMMIT;
                else if (wdog_hit)  state_d = ST_FAULT;
            end
            ST_COMMIT, ST_WAIT: begin
                if (expire) state_d = bus.en ? ST_SAMPLE : ST_IDLE;
                else        state_d = ST_WAIT;
            end
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            period_q       <= '0;
            exec_cnt_q     <= '0;
            in_image_q     <= '0;
            in_strobe_q    <= 1'b0;
            core_restart_q <= 1'b0;
            core_run_q     <= 1'b0;
            out_commit_q   <= 1'b0;
            scan_clk_q     <= 1'b0;
            overrun_q      <= 1'b0;
            fault_q        <= 1'b0;
            scan_count_q   <= '0;
            last_len_q     <= '0;
        end else begin
            state_q        <= state_d;
            in_strobe_q    <= (state_d == ST_SAMPLE);
            core_restart_q <= (state_d == ST_RESTART);
            core_run_q     <= (state_d == ST_EXEC);
            out_commit_q   <= (state_d == ST_COMMIT);
            if (state_d == ST_SAMPLE) scan_clk_q <= ~scan_clk_q;
            if (state_d == ST_FAULT)  fault_q    <= 1'b1;

            if (state_q == ST_SAMPLE) begin
                in_image_q <= bus.ui_in;
                period_q   <= bus.period;
            end

            if (state_q == ST_RESTART)   exec_cnt_q <= '0;
            else if (state_q == ST_EXEC) exec_cnt_q <= exec_cnt_q + EXEC_W'(1);

            if (state_q == ST_COMMIT) begin
                scan_count_q <= scan_count_q + CNT_W'(1);
                last_len_q   <= len_sat;
            end

            if (state_q == ST_COMMIT && scan_late) overrun_q <= 1'b1;
            else if (bus.overrun_clr)              overrun_q <= 1'b0;
        end
    end

    assign bus.in_image       = in_image_q;
    assign bus.in_strobe      = in_strobe_q;
    assign bus.core_restart   = core_restart_q;
    assign bus.core_run       = core_run_q;
    assign bus.out_commit     = out_commit_q;
    assign bus.scan_cycle_clk = scan_clk_q;
    assign bus.overrun        = overrun_q;
    assign bus.fault          = fault_q;
    assign bus.scan_count     = scan_count_q;
    assign bus.last_scan_len  = last_len_q;

endmodule

// File: tb/tb_vslc_scan_scheduler.sv
// Directed + randomized scans checked against a per-scan arithmetic model of scan timing.
module tb_vslc_scan_scheduler;

    localparam int PW = 24;
    localparam int CW = 16;
    localparam int WD = 16;
    localparam int MIN_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vslc_scan_scheduler_if #(.PERIOD_W(PW), .CNT_W(CW)) bus ();

    vslc_scan_scheduler #(.PERIOD_W(PW), .WDOG_LIMIT(WD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cnt_m  = 0;
    bit ov_m   = 1'b0;
    bit sclk_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":in_image"},      32'(bus.in_image), 0);
        chk({tag, ":in_strobe"},     32'(bus.in_strobe), 0);
        chk({tag, ":core_restart"},  32'(bus.core_restart), 0);
        chk({tag, ":core_run"},      32'(bus.core_run), 0);
        chk({tag, ":out_commit"},    32'(bus.out_commit), 0);
        chk({tag, ":scan_cycle_clk"},32'(bus.scan_cycle_clk), 0);
        chk({tag, ":overrun"},       32'(bus.overrun), 0);
        chk({tag, ":fault"},         32'(bus.fault), 0);
        chk({tag, ":scan_count"},    32'(bus.scan_count), 0);
        chk({tag, ":last_scan_len"}, 32'(bus.last_scan_len), 0);
    endtask

    task automatic wait_strobe(input int exp_k, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus.in_strobe && k < exp_k + 8);
        chk({tag, ":strobe_latency"}, 32'(k), 32'(exp_k));
    endtask

    // Called in a SAMPLE cycle. e = EXEC cycles until core_done, clr_mode 1/2 pulses
    // overrun_clr in RESTART/COMMIT, after: 0 continue, 1 drop en and expect IDLE, 2 return.
    task automatic do_scan(input int p, input int e, input bit hold_done,
                           input int clr_mode, input int after, input string tag);
        int nat, eff, len, k, seen;
        bit [7:0] ui;
        nat = e + 3;
        eff = (p > MIN_LEN) ? p : MIN_LEN;
        len = (p > nat) ? p : nat;
        sclk_m = ~sclk_m;
        chk({tag, ":sample_strobe"}, 32'(bus.in_strobe), 1);
        chk({tag, ":scan_cycle_clk"}, 32'(bus.scan_cycle_clk), 32'(sclk_m));
        ui = 8'($urandom);
        bus.ui_in = ui;
        bus.period = PW'(p);
        bus.core_done = hold_done;
        tick();
        chk({tag, ":restart"}, 32'(bus.core_restart), 1);
        chk({tag, ":image"}, 32'(bus.in_image), 32'(ui));
        bus.ui_in = ~ui;
        bus.period = PW'($urandom_range(0, 40));
        if (!hold_done) bus.core_done = 1'($urandom_range(0, 1));
        if (clr_mode == 1) begin
            bus.overrun_clr = 1'b1;
            ov_m = 1'b0;
        end
        for (k = 2; k <= e + 1; k++) begin
            tick();
            bus.overrun_clr = 1'b0;
            chk({tag, ":run"}, 32'(bus.core_run), 1);
            if (k == 2 && clr_mode == 1) chk({tag, ":overrun_cleared"}, 32'(bus.overrun), 32'(ov_m));
            bus.core_done = hold_done || (k == e + 1);
            if (after == 1 && k == 2) bus.en = 1'b0;
        end
        tick();
        chk({tag, ":commit"}, 32'(bus.out_commit), 1);
        chk({tag, ":image_stable"}, 32'(bus.in_image), 32'(ui));
        bus.core_done = hold_done;
        if (clr_mode == 2) bus.overrun_clr = 1'b1;
        if (nat > eff)          ov_m = 1'b1;
        else if (clr_mode == 2) ov_m = 1'b0;
        cnt_m = (cnt_m + 1) % 65536;
        tick();
        bus.overrun_clr = 1'b0;
        chk({tag, ":scan_count"}, 32'(bus.scan_count), 32'(cnt_m));
        chk({tag, ":last_scan_len"}, 32'(bus.last_scan_len), 32'(nat));
        chk({tag, ":overrun"}, 32'(bus.overrun), 32'(ov_m));
        if (after == 0) begin
            k = nat;
            while (!bus.in_strobe && k < len + 6) begin
                tick();
                k++;
            end
            chk({tag, ":scan_len"}, 32'(k), 32'(len));
        end else if (after == 1) begin
            seen = 0;
            for (int i = 0; i < len + 6; i++) begin
                if (bus.in_strobe) seen++;
                tick();
            end
            chk({tag, ":no_strobe_when_disabled"}, 32'(seen), 0);
            chk({tag, ":idle_run"}, 32'(bus.core_run), 0);
        end
    endtask

    task automatic do_fault();
        int seen;
        sclk_m = ~sclk_m;
        chk("fault:sample_strobe", 32'(bus.in_strobe), 1);
        bus.core_done = 1'b0;
        bus.period = PW'(8);
        tick();
        chk("fault:restart", 32'(bus.core_restart), 1);
        for (int j = 1; j <= WD; j++) begin
            tick();
            if (j == 1 || j == WD) chk("fault:run", 32'(bus.core_run), 1);
            if (j == WD) chk("fault:not_early", 32'(bus.fault), 0);
        end
        tick();
        chk("fault:set", 32'(bus.fault), 1);
        chk("fault:run_off", 32'(bus.core_run), 0);
        seen = 0;
        bus.core_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.in_strobe || bus.core_restart || bus.core_run || bus.out_commit) seen++;
        end
        chk("fault:no_activity", 32'(seen), 0);
        chk("fault:sticky", 32'(bus.fault), 1);
        bus.core_done = 1'b0;
        rst = 1'b1;
        tick();
        check_zero("fault_rst");
        rst = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.period = '0;
        bus.ui_in = '0;
        bus.core_done = 1'b0;
        bus.overrun_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");

        rst = 1'b0;
        bus.en = 1'b1;
        wait_strobe(1, "first");
        do_scan(10, 3, 1'b0, 0, 0, "basic_p10");
        do_scan(6, 8, 1'b0, 0, 0, "overrun_p6");
        do_scan(20, 2, 1'b0, 1, 0, "clr");
        do_scan(6, 8, 1'b0, 2, 0, "set_wins");
        do_scan(8, 2, 1'b0, 2, 0, "clr_commit");
        repeat (4) do_scan(0, 1, 1'b1, 0, 0, "p0_b2b");
        for (int i = 0; i < 12; i++)
            do_scan($urandom_range(0, 16), $urandom_range(1, 12), 1'b0,
                    $urandom_range(0, 2), 0, "rand");
        do_scan(0, WD, 1'b0, 0, 0, "wdog_edge_done_wins");
        do_scan(12, 3, 1'b0, 0, 1, "en_drop");

        bus.en = 1'b1;
        wait_strobe(1, "reenable");
        do_scan(20, 2, 1'b0, 0, 2, "rst_in_wait");
        tick();
        rst = 1'b1;
        tick();
        check_zero("rst_wait");
        cnt_m = 0;
        ov_m = 1'b0;
        sclk_m = 1'b0;
        rst = 1'b0;
        bus.en = 1'b0;
        repeat (3) tick();
        chk("rst_wait:idle", 32'(bus.in_strobe), 0);
        bus.en = 1'b1;
        wait_strobe(1, "after_rst");
        do_fault();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
